pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the five-stage RISC-V core. It merges load-use stall detection, taken-branch flushing and multi-cycle data-memory wait handling into one set of per-stage write-enable, bubble and flush controls. A small state machine tracks outstanding memory waits and halts the core if a wait times out. Saturating performance counters record how many cycles each hazard class costs. It sits beside the pipeline registers and drives every stage enable.

---
 rtl/riscv_pipe_pkg.sv | 32 +++
 rtl/hazard_sat_counter.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - opcode constants, hazard FSM state type and register-usage decode
package riscv_pipe_pkg;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_MWAIT = 2'd1,
    HZ_HALT  = 2'd2
  } hz_state_t;

  // Returns {uses_rs2, uses_rs1}; unknown opcodes read no registers.
  function automatic logic [1:0] opc_reg_use(input logic [4:0] opc);
    logic [1:0] use_v;
    use_v = 2'b00;
    case (opc)
      OPC_OPIMM, OPC_JALR, OPC_LOAD:  use_v = 2'b01;
      OPC_OP, OPC_STORE, OPC_BRANCH:  use_v = 2'b11;
      default:                        use_v = 2'b00;
    endcase
    return use_v;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// rtl/hazard_sat_counter.sv - saturating event counter used for hazard cycle accounting
module hazard_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - merges load-use, branch flush and memory-wait hazards into stage controls
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_opcode,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memr,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_memr,
  input  logic             ex_mem_memw,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WC_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  hz_state_t       state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

  logic       halted_q;
  logic [1:0] reg_use;
  logic       mem_pend;
  logic       lu;
  logic       fz;
  logic       br_win;
  logic       lu_win;

  assign halted_q = (state_q == HZ_HALT);
  assign reg_use  = opc_reg_use(if_id_opcode);
  assign mem_pend = ex_mem_memr | ex_mem_memw;

  assign lu = id_ex_memr && (id_ex_rd != 5'd0) &&
              ((reg_use[0] && (id_ex_rd == if_id_rs1)) ||
               (reg_use[1] && (id_ex_rd == if_id_rs2)));

  assign fz     = (mem_pend && !dmem_ready) || halted_q;
  assign br_win = !fz && ex_branch_taken;
  // A taken branch squashes the IF/ID instruction, so its load-use hazard is moot.
  assign lu_win = !fz && !ex_branch_taken && lu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      HZ_RUN: begin
        if (mem_pend && !dmem_ready) begin
          state_d    = HZ_MWAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      HZ_MWAIT: begin
        if (dmem_ready) begin
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_LAST) begin
          state_d = HZ_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      HZ_HALT: begin
        state_d = HZ_HALT;
      end
      default: begin
        state_d    = HZ_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_write   = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (fz) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (br_win) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu_win) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign halted = halted_q;

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (lu_win),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fz && !halted_q),
    .count (freeze_cnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_win),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CW = 3;

  localparam logic [4:0] OP    = 5'b01100;
  localparam logic [4:0] OPIMM = 5'b00100;
  localparam logic [4:0] STORE = 5'b01000;
  localparam logic [4:0] LUI   = 5'b01101;
  localparam logic [4:0] NONE  = 5'b11111;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble}
  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] RST  = 7'b0010101;
  localparam logic [6:0] FZ   = 7'b0000001;
  localparam logic [6:0] BR   = 7'b1111110;
  localparam logic [6:0] LU   = 7'b0001110;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    if_id_opcode, if_id_rs1, if_id_rs2, id_ex_rd;
  logic          id_ex_memr, ex_branch_taken, ex_mem_memr, ex_mem_memw, dmem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic          ex_mem_write, mem_wb_bubble, halted;
  logic [CW-1:0] stall_cnt, freeze_cnt, flush_cnt;

  typedef struct {
    logic [6:0]    ctrl;
    logic          halt;
    logic [CW-1:0] s;
    logic [CW-1:0] f;
    logic [CW-1:0] fl;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    passes = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_id_opcode    (if_id_opcode),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .id_ex_rd        (id_ex_rd),
    .id_ex_memr      (id_ex_memr),
    .ex_branch_taken (ex_branch_taken),
    .ex_mem_memr     (ex_mem_memr),
    .ex_mem_memw     (ex_mem_memw),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_bubble   (mem_wb_bubble),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .freeze_cnt      (freeze_cnt),
    .flush_cnt       (flush_cnt)
  );

  logic [6:0] ctrl_now;
  assign ctrl_now = {pc_write, if_id_write, if_id_flush, id_ex_write,
                     id_ex_bubble, ex_mem_write, mem_wb_bubble};

  task automatic step(input string nm, input logic rv, input logic [4:0] opc,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic lm, input logic br, input logic mr, input logic mw,
                      input logic rdy, input logic [6:0] ec, input logic eh,
                      input int es, input int ef, input int efl);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rv;
    if_id_opcode    = opc;
    if_id_rs1       = r1;
    if_id_rs2       = r2;
    id_ex_rd        = rd;
    id_ex_memr      = lm;
    ex_branch_taken = br;
    ex_mem_memr     = mr;
    ex_mem_memw     = mw;
    dmem_ready      = rdy;
    e.ctrl = ec;
    e.halt = eh;
    e.s    = CW'(es);
    e.f    = CW'(ef);
    e.fl   = CW'(efl);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      checks++;
      if (ctrl_now === e.ctrl) passes++;
      else $display("FAIL %s ctrl: got %b want %b", nm, ctrl_now, e.ctrl);
      checks++;
      if (halted === e.halt) passes++;
      else $display("FAIL %s halted: got %b want %b", nm, halted, e.halt);
      checks++;
      if (stall_cnt === e.s) passes++;
      else $display("FAIL %s stall_cnt: got %0d want %0d", nm, stall_cnt, e.s);
      checks++;
      if (freeze_cnt === e.f) passes++;
      else $display("FAIL %s freeze_cnt: got %0d want %0d", nm, freeze_cnt, e.f);
      checks++;
      if (flush_cnt === e.fl) passes++;
      else $display("FAIL %s flush_cnt: got %0d want %0d", nm, flush_cnt, e.fl);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; if_id_opcode = NONE; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
    id_ex_memr = 1'b0; ex_branch_taken = 1'b0; ex_mem_memr = 1'b0; ex_mem_memw = 1'b0;
    dmem_ready = 1'b1;

    // reset, load-use detection and opcode gating
    step("reset_lu_in",   0, OP,    5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 1, RST,  0, 0, 0, 0);
    step("reset_hold",    0, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, RST,  0, 0, 0, 0);
    step("lu_op_rs2",     1, OP,    5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 1, LU,   0, 0, 0, 0);
    step("lu_clears",     1, OP,    5'd1, 5'd5, 5'd0, 0, 0, 0, 0, 1, NORM, 0, 1, 0, 0);
    step("opimm_no_rs2",  1, OPIMM, 5'd3, 5'd5, 5'd5, 1, 0, 0, 0, 1, NORM, 0, 1, 0, 0);
    step("rd_zero",       1, OP,    5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1, NORM, 0, 1, 0, 0);
    step("lu_opimm_rs1",  1, OPIMM, 5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 1, LU,   0, 1, 0, 0);
    step("lui_no_use",    1, LUI,   5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 1, NORM, 0, 2, 0, 0);
    step("lu_store_rs2",  1, STORE, 5'd1, 5'd9, 5'd9, 1, 0, 0, 0, 1, LU,   0, 2, 0, 0);
    step("idle_a",        1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, NORM, 0, 3, 0, 0);
    // branch priority and memory wait release
    step("reset_b",       0, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, RST,  0, 3, 0, 0);
    step("br_over_lu",    1, OP,    5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 1, BR,   0, 0, 0, 0);
    step("idle_b",        1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, NORM, 0, 0, 0, 1);
    step("fz_over_br1",   1, NONE,  5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0, FZ,   0, 0, 0, 1);
    step("fz_over_br2",   1, NONE,  5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0, FZ,   0, 0, 1, 1);
    step("fz_store3",     1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, FZ,   0, 0, 2, 1);
    step("release_br",    1, NONE,  5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, BR,   0, 0, 3, 1);
    step("idle_c",        1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, NORM, 0, 0, 3, 2);
    step("rewait",        1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, FZ,   0, 0, 3, 2);
    step("rewait_done",   1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, NORM, 0, 0, 4, 2);
    // timeout to halt
    step("reset_c",       0, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, RST,  0, 0, 4, 2);
    step("to_1",          1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FZ,   0, 0, 0, 0);
    step("to_2",          1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FZ,   0, 0, 1, 0);
    step("to_3",          1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FZ,   0, 0, 2, 0);
    step("to_4",          1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FZ,   0, 0, 3, 0);
    step("halted_rdy",    1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, FZ,   1, 0, 4, 0);
    step("halted_br_lu",  1, OP,    5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 1, FZ,   1, 0, 4, 0);
    step("halt_reset",    0, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, RST,  1, 0, 4, 0);
    step("after_halt",    1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, NORM, 0, 0, 0, 0);
    // reset in the middle of a wait restarts the timeout window
    step("mw_1",          1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, FZ,   0, 0, 0, 0);
    step("mw_2",          1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, FZ,   0, 0, 1, 0);
    step("mw_reset",      0, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, RST,  0, 0, 2, 0);
    step("mw_re1",        1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, FZ,   0, 0, 0, 0);
    step("mw_re2",        1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, FZ,   0, 0, 1, 0);
    step("mw_re3",        1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, FZ,   0, 0, 2, 0);
    step("mw_re4",        1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, FZ,   0, 0, 3, 0);
    step("mw_halted",     1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, FZ,   1, 0, 4, 0);
    step("reset_d",       0, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, RST,  1, 0, 4, 0);
    // saturation of the 3-bit stall counter
    for (int i = 0; i < 10; i++) begin
      step("sat_lu",      1, OP,    5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 1, LU,   0, (i < 7) ? i : 7, 0, 0);
    end
    step("sat_final",     1, NONE,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, NORM, 0, 7, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
